pixel_stream_tx: RTL and testbench

// Frame scanner and byte transmitter at the display end of the pixel path. Sweeps

---
 rtl/pixel_stream_tx_if.sv | 19 +
 rtl/pixel_stream_tx.sv | 131 +++++++++++++
 tb/tb_pixel_stream_tx.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_stream_tx_if.sv
// Byte stream from the frame scanner to the LCD serializer.
// A byte moves on any cycle where tx_valid and tx_ready are both high.
interface pixel_stream_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/pixel_stream_tx.sv
// Raster scanner: walks pixelcnt over WIDTH x HEIGHT, samples the renderer pixel
// PIX_LAT cycles later and sends it as an RGB565 word, high byte first.
module pixel_stream_tx #(
    parameter int unsigned WIDTH    = 240,
    parameter int unsigned HEIGHT   = 240,
    parameter int unsigned PIX_LAT  = 0,
    parameter logic [15:0] FG_COLOR = 16'hFFFF,
    parameter logic [15:0] BG_COLOR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        frame_abort,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] pixelcnt,
    input  logic        pixel,
    pixel_stream_tx_if.master tx
);

    localparam int unsigned NumPix  = WIDTH * HEIGHT;
    localparam logic [15:0] LastPix = 16'(NumPix - 1);
    localparam logic [1:0]  LatInit = 2'(PIX_LAT);

    typedef enum logic [1:0] {StIdle, StFetch, StSendHi, StSendLo} state_e;

    state_e      state_q, state_d;
    logic [15:0] pixelcnt_q, pixelcnt_d;
    logic [15:0] color_q, color_d;
    logic [1:0]  wait_q, wait_d;
    logic        abort_q, abort_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        xfer;

    assign xfer = tx.tx_valid & tx.tx_ready;

    always_comb begin
        state_d    = state_q;
        pixelcnt_d = pixelcnt_q;
        color_d    = color_q;
        wait_d     = wait_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        // Sticky abort; only acted on once the current pixel's low byte has gone.
        abort_d    = abort_q | (busy_q & frame_abort);
        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    pixelcnt_d = 16'd0;
                    busy_d     = 1'b1;
                    wait_d     = LatInit;
                    abort_d    = 1'b0;
                    state_d    = StFetch;
                end
            end
            StFetch: begin
                if (wait_q == 2'd0) begin
                    color_d = pixel ? FG_COLOR : BG_COLOR;
                    state_d = StSendHi;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            StSendHi: begin
                if (xfer) begin
                    state_d = StSendLo;
                end
            end
            StSendLo: begin
                if (xfer) begin
                    if (pixelcnt_q == LastPix) begin
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        pixelcnt_d = 16'd0;
                        abort_d    = 1'b0;
                        state_d    = StIdle;
                    end else if (abort_q) begin
                        busy_d     = 1'b0;
                        pixelcnt_d = 16'd0;
                        abort_d    = 1'b0;
                        state_d    = StIdle;
                    end else begin
                        pixelcnt_d = pixelcnt_q + 16'd1;
                        wait_d     = LatInit;
                        state_d    = StFetch;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pixelcnt_q <= 16'd0;
            color_q    <= 16'd0;
            wait_q     <= 2'd0;
            abort_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pixelcnt_q <= pixelcnt_d;
            color_q    <= color_d;
            wait_q     <= wait_d;
            abort_q    <= abort_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Valid and data come straight from registered state, never from tx_ready.
    always_comb begin
        tx.tx_valid = 1'b0;
        tx.tx_data  = 8'h00;
        if (state_q == StSendHi) begin
            tx.tx_valid = 1'b1;
            tx.tx_data  = color_q[15:8];
        end else if (state_q == StSendLo) begin
            tx.tx_valid = 1'b1;
            tx.tx_data  = color_q[7:0];
        end
    end

    assign busy       = busy_q;
    assign frame_done = done_q;
    assign pixelcnt   = pixelcnt_q;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Bench for pixel_stream_tx: a small 4x2 raster plus two 240-wide rasters at
// pixel latencies 0 and 3, compared against a bitmap-driven byte model.
module tb_pixel_stream_tx;

    localparam logic [15:0] FgA = 16'hF800;
    localparam logic [15:0] BgA = 16'h001F;
    localparam int NA = 8;
    localparam int NB = 240 * 5;
    localparam int NC = 240 * 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int vectors = 0;
    int miscompares = 0;

    logic start_a, abort_a, busy_a, done_a, pix_a;
    logic start_b, abort_b, busy_b, done_b, pix_b;
    logic start_c, abort_c, busy_c, done_c, pix_c;
    logic [15:0] pc_a, pc_b, pc_c;

    pixel_stream_tx_if if_a ();
    pixel_stream_tx_if if_b ();
    pixel_stream_tx_if if_c ();

    pixel_stream_tx #(.WIDTH(4), .HEIGHT(2), .PIX_LAT(1), .FG_COLOR(FgA), .BG_COLOR(BgA)) u_dut (
        .clk(clk), .rst_n(rst_n), .frame_start(start_a), .frame_abort(abort_a), .busy(busy_a),
        .frame_done(done_a), .pixelcnt(pc_a), .pixel(pix_a), .tx(if_a)
    );
    pixel_stream_tx #(.WIDTH(240), .HEIGHT(5), .PIX_LAT(0)) u_dut_lat0 (
        .clk(clk), .rst_n(rst_n), .frame_start(start_b), .frame_abort(abort_b), .busy(busy_b),
        .frame_done(done_b), .pixelcnt(pc_b), .pixel(pix_b), .tx(if_b)
    );
    pixel_stream_tx #(.WIDTH(240), .HEIGHT(4), .PIX_LAT(3)) u_dut_lat3 (
        .clk(clk), .rst_n(rst_n), .frame_start(start_c), .frame_abort(abort_c), .busy(busy_c),
        .frame_done(done_c), .pixelcnt(pc_c), .pixel(pix_c), .tx(if_c)
    );

    // Renderers: a bitmap looked up by pixelcnt, delayed by each instance's latency.
    logic pat_a [NA];
    logic pat_b [NB];
    logic pat_c [NC];
    logic [2:0] pipe_c;
    always @(posedge clk) pix_a <= pat_a[pc_a[2:0]];
    assign pix_b = (pc_b < 16'(NB)) ? pat_b[pc_b] : 1'b0;
    always @(posedge clk) pipe_c <= {pipe_c[1:0], (pc_c < 16'(NC)) ? pat_c[pc_c] : 1'b0};
    assign pix_c = pipe_c[2];

    // Monitors sample on the falling edge, half a cycle clear of the active edge.
    logic [7:0]  cap_a [$];
    logic [15:0] pcs_a [$];
    logic [7:0]  cap_b [$];
    logic [7:0]  cap_c [$];
    int done_cnt_a, done_cnt_b, done_cnt_c, stall_viol, busy_cyc_c;
    logic [15:0] last_pc_b, last_pc_c, done_pc_b, done_pc_c;
    logic prev_stall;
    logic [7:0] prev_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (if_a.tx_valid && if_a.tx_ready) begin
                cap_a.push_back(if_a.tx_data);
                pcs_a.push_back(pc_a);
            end
            if (done_a) done_cnt_a++;
            if (prev_stall && (!if_a.tx_valid || if_a.tx_data !== prev_data)) stall_viol++;
            prev_stall = if_a.tx_valid && !if_a.tx_ready;
            prev_data  = if_a.tx_data;
            if (if_b.tx_valid && if_b.tx_ready) begin
                cap_b.push_back(if_b.tx_data);
                last_pc_b = pc_b;
            end
            if (done_b) begin
                done_cnt_b++;
                done_pc_b = last_pc_b;
            end
            if (if_c.tx_valid && if_c.tx_ready) begin
                cap_c.push_back(if_c.tx_data);
                last_pc_c = pc_c;
            end
            if (done_c) begin
                done_cnt_c++;
                done_pc_c = last_pc_c;
            end
            if (busy_c) busy_cyc_c++;
        end
    end

    // Reference: byte i of a frame is the high/low half of pixel i/2's colour.
    function automatic logic [7:0] exp_a(int i);
        logic [15:0] c;
        c = pat_a[i / 2] ? FgA : BgA;
        return (i % 2 == 1) ? c[7:0] : c[15:8];
    endfunction

    function automatic int bad_bytes_a(int n);
        int bad = 0;
        for (int i = 0; i < n && i < cap_a.size(); i++) begin
            if (cap_a[i] !== exp_a(i) || pcs_a[i] !== 16'(i / 2)) bad++;
        end
        return bad;
    endfunction

    task automatic clear_a();
        cap_a.delete();
        pcs_a.delete();
        done_cnt_a = 0;
        stall_viol = 0;
    endtask

    task automatic random_pat_a();
        for (int i = 0; i < NA; i++) pat_a[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic pulse_start_a();
        @(posedge clk); #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    task automatic run_until_idle_a(input bit stall, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if_a.tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!busy_a) begin
                ok = 1'b1;
                break;
            end
        end
        if_a.tx_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {start_a, abort_a, start_b, abort_b, start_c, abort_c} = '0;
        if_a.tx_ready = 1'b0;
        if_b.tx_ready = 1'b0;
        if_c.tx_ready = 1'b0;
        for (int i = 0; i < NA; i++) pat_a[i] = 1'b0;
        #12;
        vectors++;
        if ({busy_a, done_a, if_a.tx_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_ctrl: busy/done/valid=%b want 000", {busy_a, done_a, if_a.tx_valid});
        end
        vectors++;
        if (pc_a !== 16'd0 || if_a.tx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_regs: pixelcnt=%0d tx_data=%h want 0 00", pc_a, if_a.tx_data);
        end
        vectors++;
        if ({busy_b, busy_c, if_b.tx_valid, if_c.tx_valid} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_big: busy/valid=%b want 0000",
                     {busy_b, busy_c, if_b.tx_valid, if_c.tx_valid});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        if_a.tx_ready = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        int bad;
        for (int i = 0; i < NA; i++) pat_a[i] = 1'(i % 2);
        clear_a();
        pulse_start_a();
        run_until_idle_a(1'b0, 400, ok);
        bad = bad_bytes_a(16);
        vectors++;
        if (!ok || cap_a.size() != 16) begin
            miscompares++;
            $display("FAIL basic_count: idle=%0d bytes=%0d want 1 16", ok, cap_a.size());
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL basic_bytes: %0d wrong byte/pixelcnt entries, want 0", bad);
        end
        vectors++;
        if (cap_a.size() >= 4 && {cap_a[0], cap_a[1], cap_a[2], cap_a[3]} !== 32'h001F_F800) begin
            miscompares++;
            $display("FAIL basic_order: first bytes %h %h %h %h want 00 1f f8 00",
                     cap_a[0], cap_a[1], cap_a[2], cap_a[3]);
        end
        vectors++;
        if (done_cnt_a != 1 || busy_a !== 1'b0 || pc_a !== 16'd0) begin
            miscompares++;
            $display("FAIL basic_end: done=%0d busy=%b pixelcnt=%0d want 1 0 0",
                     done_cnt_a, busy_a, pc_a);
        end
    endtask

    task automatic test_stall();
        bit ok;
        int bad;
        for (int it = 0; it < 3; it++) begin
            random_pat_a();
            clear_a();
            pulse_start_a();
            run_until_idle_a(1'b1, 1000, ok);
            bad = bad_bytes_a(16);
            vectors++;
            if (!ok || cap_a.size() != 16 || bad != 0 || done_cnt_a != 1) begin
                miscompares++;
                $display("FAIL stall_frame[%0d]: idle=%0d bytes=%0d bad=%0d done=%0d want 1 16 0 1",
                         it, ok, cap_a.size(), bad, done_cnt_a);
            end
            vectors++;
            if (stall_viol != 0) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: %0d unstable stalled cycles, want 0", it, stall_viol);
            end
        end
    endtask

    task automatic test_abort();
        bit ok;
        bit hit = 1'b0;
        random_pat_a();
        clear_a();
        pulse_start_a();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (cap_a.size() == 6 && if_a.tx_valid && pc_a == 16'd3) begin
                hit = 1'b1;
                break;
            end
        end
        abort_a = 1'b1;
        @(posedge clk); #1;
        abort_a = 1'b0;
        run_until_idle_a(1'b0, 400, ok);
        vectors++;
        if (!hit || !ok || cap_a.size() != 8 || bad_bytes_a(8) != 0) begin
            miscompares++;
            $display("FAIL abort_bytes: hit=%0d idle=%0d bytes=%0d bad=%0d want 1 1 8 0",
                     hit, ok, cap_a.size(), bad_bytes_a(8));
        end
        vectors++;
        if (done_cnt_a != 0 || busy_a !== 1'b0 || pc_a !== 16'd0) begin
            miscompares++;
            $display("FAIL abort_end: done=%0d busy=%b pixelcnt=%0d want 0 0 0",
                     done_cnt_a, busy_a, pc_a);
        end
        random_pat_a();
        clear_a();
        pulse_start_a();
        run_until_idle_a(1'b0, 400, ok);
        vectors++;
        if (!ok || cap_a.size() != 16 || bad_bytes_a(16) != 0 || done_cnt_a != 1) begin
            miscompares++;
            $display("FAIL abort_restart: bytes=%0d bad=%0d done=%0d want 16 0 1",
                     cap_a.size(), bad_bytes_a(16), done_cnt_a);
        end
    endtask

    task automatic test_busy_start();
        bit ok = 1'b0;
        random_pat_a();
        clear_a();
        // Abort while idle is ignored; start together with abort begins a clean frame.
        @(posedge clk); #1;
        abort_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        abort_a = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (!busy_a) begin
                ok = 1'b1;
                break;
            end
            start_a = ($urandom_range(0, 2) == 0);
        end
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (!ok || cap_a.size() != 16 || bad_bytes_a(16) != 0 || done_cnt_a != 1) begin
            miscompares++;
            $display("FAIL busy_start: bytes=%0d bad=%0d done=%0d want 16 0 1",
                     cap_a.size(), bad_bytes_a(16), done_cnt_a);
        end
        vectors++;
        if (busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_start_idle: busy=%b want 0", busy_a);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit hit = 1'b0;
        random_pat_a();
        clear_a();
        pulse_start_a();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (cap_a.size() == 10 && if_a.tx_valid && pc_a == 16'd5) begin
                hit = 1'b1;
                break;
            end
        end
        rst_n = 1'b0;
        #2;
        vectors++;
        if (!hit || {busy_a, done_a, if_a.tx_valid} !== 3'b000 || pc_a !== 16'd0 ||
            if_a.tx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid: hit=%0d busy/done/valid=%b pixelcnt=%0d data=%h want 1 000 0 00",
                     hit, {busy_a, done_a, if_a.tx_valid}, pc_a, if_a.tx_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (done_cnt_a != 0 || cap_a.size() != 10 || busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_quiet: done=%0d bytes=%0d busy=%b want 0 10 0",
                     done_cnt_a, cap_a.size(), busy_a);
        end
        clear_a();
        pulse_start_a();
        run_until_idle_a(1'b0, 400, ok);
        vectors++;
        if (!ok || cap_a.size() != 16 || bad_bytes_a(16) != 0 || done_cnt_a != 1) begin
            miscompares++;
            $display("FAIL reset_mid_restart: bytes=%0d bad=%0d done=%0d want 16 0 1",
                     cap_a.size(), bad_bytes_a(16), done_cnt_a);
        end
    endtask

    task automatic test_big_raster();
        bit ok = 1'b0;
        int bad_b = 0;
        int bad_c = 0;
        for (int i = 0; i < NB; i++) pat_b[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < NC; i++) pat_c[i] = 1'($urandom_range(0, 1));
        cap_b.delete();
        cap_c.delete();
        {done_cnt_b, done_cnt_c, busy_cyc_c} = '0;
        if_c.tx_ready = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b1;
        start_c = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        start_c = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk); #1;
            if_b.tx_ready = 1'($urandom_range(0, 1));
            if (!busy_b && !busy_c) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < cap_b.size(); i++) if (cap_b[i] !== (pat_b[i / 2] ? 8'hFF : 8'h00)) bad_b++;
        for (int i = 0; i < cap_c.size(); i++) if (cap_c[i] !== (pat_c[i / 2] ? 8'hFF : 8'h00)) bad_c++;
        vectors++;
        if (!ok || cap_b.size() != 2 * NB || bad_b != 0) begin
            miscompares++;
            $display("FAIL lat0_bytes: idle=%0d bytes=%0d bad=%0d want 1 %0d 0",
                     ok, cap_b.size(), bad_b, 2 * NB);
        end
        vectors++;
        if (done_cnt_b != 1 || done_pc_b !== 16'(NB - 1)) begin
            miscompares++;
            $display("FAIL lat0_done: done=%0d at pixelcnt %0d want 1 at %0d",
                     done_cnt_b, done_pc_b, NB - 1);
        end
        vectors++;
        if (cap_c.size() != 2 * NC || bad_c != 0) begin
            miscompares++;
            $display("FAIL lat3_bytes: bytes=%0d bad=%0d want %0d 0", cap_c.size(), bad_c, 2 * NC);
        end
        vectors++;
        if (done_cnt_c != 1 || done_pc_c !== 16'(NC - 1)) begin
            miscompares++;
            $display("FAIL lat3_done: done=%0d at pixelcnt %0d want 1 at %0d",
                     done_cnt_c, done_pc_c, NC - 1);
        end
        vectors++;
        if (busy_cyc_c != NC * 6) begin
            miscompares++;
            $display("FAIL lat3_rate: busy cycles=%0d want %0d", busy_cyc_c, NC * 6);
        end
    endtask

    initial begin
        done_cnt_a = 0;
        stall_viol = 0;
        test_reset();
        test_basic();
        test_stall();
        test_abort();
        test_busy_start();
        test_reset_mid();
        test_big_raster();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
